// File: rtl/pcie_apb_master_pkg.sv
// State encoding, register record and reset value for the PCIe-to-APB bridge master.
package pcie_apb_master_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2,
    StResp   = 2'd3
  } state_e;

  typedef struct packed {
    state_e      state;
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [15:0] cnt;
    logic [31:0] rdata;
    logic        err;
  } regs_t;

  localparam regs_t pcie_apb_master_r_reset = '{
    state: StIdle,
    addr:  32'h0,
    write: 1'b0,
    wdata: 32'h0,
    wstrb: 4'h0,
    cnt:   16'h0,
    rdata: 32'h0,
    err:   1'b0
  };

  // Saturating increment so a stuck slave can never wrap the wait counter.
  function automatic logic [15:0] cnt_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

endpackage

// File: rtl/types_amba_pkg.sv
// AMBA APB bus record types shared by APB masters and slaves.
// apb_in_type is what a slave receives; apb_out_type is what a slave returns.
package types_amba_pkg;

  typedef struct packed {
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } apb_in_type;

  typedef struct packed {
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
  } apb_out_type;

endpackage

// File: rtl/pcie_apb_master.sv
// Single-outstanding PCIe request to APB master bridge with ACCESS-phase timeout.
// APB outputs and response signals are decoded from registered state only.
module pcie_apb_master
  import types_amba_pkg::*;
  import pcie_apb_master_pkg::*;
#(
  parameter int unsigned timeout_cycles = 1023
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_write,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_wstrb,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output apb_in_type  o_apbo,
  input  apb_out_type i_apbi
);

  localparam logic [15:0] TimeoutCnt = 16'(timeout_cycles);

  regs_t r_q, r_d;

  always_comb begin
    r_d = r_q;
    unique case (r_q.state)
      StIdle: begin
        if (i_req_valid) begin
          r_d.state = StSetup;
          r_d.addr  = {i_req_addr[31:2], 2'b00};
          r_d.write = i_req_write;
          r_d.wdata = i_req_wdata;
          r_d.wstrb = i_req_write ? i_req_wstrb : 4'h0;
          r_d.cnt   = 16'h0;
          r_d.rdata = 32'h0;
          r_d.err   = 1'b0;
        end
      end
      StSetup: begin
        r_d.state = StAccess;
        r_d.cnt   = 16'h0;
      end
      StAccess: begin
        // A ready slave wins over a timeout landing in the same cycle.
        if (i_apbi.pready) begin
          r_d.state = StResp;
          r_d.rdata = r_q.write ? 32'h0 : i_apbi.prdata;
          r_d.err   = i_apbi.pslverr;
        end else begin
          r_d.cnt = cnt_inc(r_q.cnt);
          if (r_d.cnt >= TimeoutCnt) begin
            r_d.state = StResp;
            r_d.rdata = r_q.write ? 32'h0 : 32'hFFFF_FFFF;
            r_d.err   = 1'b1;
          end
        end
      end
      StResp: begin
        if (i_resp_ready) begin
          r_d.state = StIdle;
        end
      end
      default: r_d.state = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= pcie_apb_master_r_reset;
    end else begin
      r_q <= r_d;
    end
  end

  always_comb begin
    o_apbo.paddr   = r_q.addr;
    o_apbo.pprot   = 3'b000;
    o_apbo.pselx   = (r_q.state == StSetup) || (r_q.state == StAccess);
    o_apbo.penable = (r_q.state == StAccess);
    o_apbo.pwrite  = r_q.write;
    o_apbo.pwdata  = r_q.wdata;
    o_apbo.pstrb   = r_q.wstrb;
  end

  assign o_req_ready  = (r_q.state == StIdle);
  assign o_resp_valid = (r_q.state == StResp);
  assign o_resp_rdata = r_q.rdata;
  assign o_resp_err   = (r_q.state == StResp) && r_q.err;

endmodule

// File: tb/tb_pcie_apb_master.sv
// Directed bench for pcie_apb_master: vector table of APB transactions plus reset corner cases.
module tb_pcie_apb_master;
  import types_amba_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  apb_in_type  apbo;
  apb_out_type apbi;

  int n_chk = 0;
  int n_fail = 0;

  pcie_apb_master #(
    .timeout_cycles(8)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_addr   (req_addr),
    .i_req_write  (req_write),
    .i_req_wdata  (req_wdata),
    .i_req_wstrb  (req_wstrb),
    .o_resp_valid (resp_valid),
    .i_resp_ready (resp_ready),
    .o_resp_rdata (resp_rdata),
    .o_resp_err   (resp_err),
    .o_apbo       (apbo),
    .i_apbi       (apbi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          waits;   // ACCESS cycles with pready low before pready rises
    logic [31:0] prdata;
    logic        slverr;
    int          hold;    // cycles i_resp_ready stays low in RESP
    int          lat;     // cycles from accept to o_resp_valid
    logic [31:0] e_paddr;
    logic [3:0]  e_pstrb;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    int acc;
    logic [31:0] rd_seen;
    @(negedge clk);
    check($sformatf("v%0d req_ready idle", idx), 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_write = v.write;
    req_wdata = v.wdata;
    req_wstrb = v.wstrb;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    check($sformatf("v%0d setup psel/pen", idx), {30'd0, apbo.pselx, apbo.penable}, 32'd2);
    check($sformatf("v%0d setup paddr", idx), apbo.paddr, v.e_paddr);
    check($sformatf("v%0d setup pstrb", idx), 32'(apbo.pstrb), 32'(v.e_pstrb));
    check($sformatf("v%0d setup pwrite", idx), 32'(apbo.pwrite), 32'(v.write));
    check($sformatf("v%0d setup pwdata", idx), apbo.pwdata, v.wdata);
    check($sformatf("v%0d setup pprot", idx), 32'(apbo.pprot), 32'd0);
    check($sformatf("v%0d setup req_ready", idx), 32'(req_ready), 32'd0);
    @(negedge clk);
    lat++;
    acc = 0;
    while (!resp_valid && lat < 60) begin
      if (acc == 0) begin
        check($sformatf("v%0d access psel/pen", idx), {30'd0, apbo.pselx, apbo.penable}, 32'd3);
      end
      if (req_ready !== 1'b0) check($sformatf("v%0d busy req_ready", idx), 32'(req_ready), 32'd0);
      apbi.pready  = (acc == v.waits);
      apbi.prdata  = v.prdata;
      apbi.pslverr = v.slverr;
      acc++;
      @(negedge clk);
      lat++;
    end
    apbi = '0;
    check($sformatf("v%0d resp_valid", idx), 32'(resp_valid), 32'd1);
    check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
    check($sformatf("v%0d resp psel/pen", idx), {30'd0, apbo.pselx, apbo.penable}, 32'd0);
    check($sformatf("v%0d rdata", idx), resp_rdata, v.e_rdata);
    check($sformatf("v%0d err", idx), 32'(resp_err), 32'(v.e_err));
    rd_seen = resp_rdata;
    for (int h = 0; h < v.hold; h++) begin
      resp_ready = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d hold%0d valid", idx, h), 32'(resp_valid), 32'd1);
      check($sformatf("v%0d hold%0d rdata", idx, h), resp_rdata, v.e_rdata);
      check($sformatf("v%0d hold%0d err", idx, h), 32'(resp_err), 32'(v.e_err));
      check($sformatf("v%0d hold%0d req_ready", idx, h), 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check($sformatf("v%0d post-hs valid", idx), 32'(resp_valid), 32'd0);
    check($sformatf("v%0d post-hs req_ready", idx), 32'(req_ready), 32'd1);
  endtask

  // Start a read and stop after `cycles` negedges past the accept (1 = SETUP, 2 = ACCESS).
  task automatic start_read(input int cycles);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h0000_0100;
    req_write = 1'b0;
    req_wdata = 32'h0;
    req_wstrb = 4'h0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0, 0, 3,
                32'h10, 4'hF, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 32'h13, 32'h0, 4'hF, 3, 32'h1234_5678, 1'b0, 0, 6,
                32'h10, 4'h0, 32'h1234_5678, 1'b0};
    vecs[2] = '{1'b0, 32'h20, 32'h0, 4'h0, 1000, 32'h5555_5555, 1'b0, 0, 10,
                32'h20, 4'h0, 32'hFFFF_FFFF, 1'b1};
    vecs[3] = '{1'b1, 32'h44, 32'h0BAD_F00D, 4'h5, 0, 32'h9999_9999, 1'b1, 5, 3,
                32'h44, 4'h5, 32'h0, 1'b1};
    vecs[4] = '{1'b1, 32'h0B, 32'hCAFE_0001, 4'h3, 1000, 32'h7777_7777, 1'b0, 2, 10,
                32'h08, 4'h3, 32'h0, 1'b1};
    vecs[5] = '{1'b0, 32'h30, 32'h0, 4'h0, 7, 32'hA5A5_0F0F, 1'b0, 0, 10,
                32'h30, 4'h0, 32'hA5A5_0F0F, 1'b0};
    vecs[6] = '{1'b0, 32'hFFFF_FFFE, 32'h0, 4'hC, 0, 32'h0000_00C3, 1'b1, 1, 3,
                32'hFFFF_FFFC, 4'h0, 32'h0000_00C3, 1'b1};

    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    req_write = 1'b0;
    req_wdata = '0;
    req_wstrb = '0;
    resp_ready = 1'b0;
    apbi = '0;
    repeat (2) @(negedge clk);
    check("reset psel/pen", {30'd0, apbo.pselx, apbo.penable}, 32'd0);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset resp_err", 32'(resp_err), 32'd0);
    check("reset paddr", apbo.paddr, 32'd0);
    check("reset rdata", resp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 7; i++) begin
      run_vec(i, vecs[i]);
    end

    // Reset while in ACCESS: transfer dropped, no response.
    start_read(2);
    check("pre-rst access penable", 32'(apbo.penable), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst-access psel/pen", {30'd0, apbo.pselx, apbo.penable}, 32'd0);
    check("rst-access resp_valid", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst-access req_ready", 32'(req_ready), 32'd1);
    apbi.pready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst-access no resp", 32'(resp_valid), 32'd0);
    apbi = '0;

    // Reset while in SETUP.
    start_read(1);
    check("pre-rst setup psel/pen", {30'd0, apbo.pselx, apbo.penable}, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    check("rst-setup psel/pen", {30'd0, apbo.pselx, apbo.penable}, 32'd0);
    check("rst-setup resp_valid", 32'(resp_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst-setup req_ready", 32'(req_ready), 32'd1);

    // A normal transfer after the aborted ones still completes.
    run_vec(7, vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pcie_apb_master.md
PCIE_APB_MASTER -- requirements
Module: pcie_apb_master

Interface
REQ-001 Parameter timeout_cycles, default 1023: maximum ACCESS-phase cycles to wait for pready before aborting.
REQ-002 i_clk  in  1  single clock; all logic is synchronous to its rising edge.
REQ-003 i_rst  in  1  synchronous active-high reset.
REQ-004 i_req_valid  in  1  request from the PCIe side is valid.
REQ-005 o_req_ready  out  1  block accepts a request this cycle.
REQ-006 i_req_addr  in  32  byte address.
REQ-007 i_req_write  in  1  1 = write, 0 = read.
REQ-008 i_req_wdata  in  32  write data.
REQ-009 i_req_wstrb  in  4  byte strobes.
REQ-010 o_resp_valid  out  1  response is valid.
REQ-011 i_resp_ready  in  1  PCIe side accepts the response.
REQ-012 o_resp_rdata  out  32  read data; 0 for writes.
REQ-013 o_resp_err  out  1  pslverr or timeout.
REQ-014 o_apbo  out  apb_in_type (types_amba_pkg)  APB master outputs: paddr, pprot, pselx, penable, pwrite, pwdata, pstrb.
REQ-015 i_apbi  in  apb_out_type (types_amba_pkg)  APB slave returns: prdata, pready, pslverr.

Function
REQ-016 FSM states: IDLE, SETUP, ACCESS, RESP.
REQ-017 IDLE: o_req_ready = 1; on i_req_valid, latch addr (bits [1:0] forced 0), write, wdata, and wstrb (forced 4'h0 for reads), then go to SETUP.
REQ-018 SETUP (exactly 1 cycle): pselx = 1, penable = 0, paddr/pwrite/pwdata/pstrb from latched values, pprot = 3'b000; next state ACCESS; clear timeout counter.
REQ-019 ACCESS: pselx = 1, penable = 1; all other APB outputs held stable.
REQ-020 In ACCESS with pready = 1: capture prdata (reads only, else 0) and pslverr, then go to RESP; pselx and penable drop on the next cycle.
REQ-021 In ACCESS with pready = 0: increment the counter; when it reaches timeout_cycles, go to RESP with err = 1 and rdata = 32'hFFFF_FFFF (reads) or 0 (writes).
REQ-022 pready and timeout in the same cycle: pready wins and the captured response is used.
REQ-023 RESP: o_resp_valid = 1 and data stable until i_resp_ready; on the handshake go to IDLE.
REQ-024 o_req_ready = 0 in every state except IDLE; at most one transaction outstanding.
REQ-025 Minimum latency: request accepted in cycle N, o_resp_valid at N+3 when pready is high on the first ACCESS cycle.
REQ-026 Back-to-back operation: the next request can be accepted in the cycle after the RESP handshake.
REQ-027 Timeout counter is 16 bits wide and saturates; timeout_cycles must be in the range 1 to 65535.

Reset
REQ-028 i_rst = 1 at a clock edge: state becomes IDLE; pselx, penable, o_resp_valid and o_resp_err become 0; all latched registers become 0.
REQ-029 Reset during SETUP or ACCESS abandons the APB transfer immediately; no response is generated.
REQ-030 o_req_ready = 1 on the first cycle after reset is released.

Structure
REQ-031 Package pcie_apb_master_pkg holds: the state enum, a registers struct (state, addr, write, wdata, wstrb, cnt, rdata, err), and the reset constant pcie_apb_master_r_reset.
REQ-032 Single module: a combinational next-state process plus one synchronous register process; no sub-module.

Verification
REQ-033 Write 0x10 data 0xDEADBEEF strb 0xF, pready = 1 immediately -> one SETUP cycle, one ACCESS cycle, pstrb = 0xF, response err = 0 at N+3.
REQ-034 Read 0x13, slave returns 0x12345678 after 3 wait states -> paddr = 0x10, pstrb = 0, rdata = 0x12345678, err = 0.
REQ-035 Read with pready never asserted, timeout_cycles = 8 -> err = 1, rdata = 0xFFFFFFFF, pselx drops; next request is accepted.
REQ-036 pslverr = 1 with pready on a write -> err = 1, rdata = 0; i_resp_ready held low 5 cycles -> response stable and o_req_ready stays 0.
REQ-037 Assert i_rst mid-ACCESS -> pselx = penable = 0 and o_resp_valid = 0 on the next cycle; o_req_ready = 1 after release.
